// File: rtl/mby_msh_pkg.sv
// Shared types and default sizes for the mesh memory node datapaths.
package mby_msh_pkg;

   localparam int MSH_MEM_ADDR_W = 14;
   localparam int MSH_MEM_DATA_W = 512;
   localparam int MSH_TAG_W      = 8;
   localparam int MSH_MEM_RD_LAT = 2;

   typedef struct packed {
      logic [MSH_MEM_DATA_W-1:0] data;
      logic [MSH_TAG_W-1:0]      tag;
      logic                      err;
   } msh_rd_rsp_t;

endpackage

// File: rtl/mby_msh_rsp_fifo.sv
// In-order DEPTH x WIDTH response FIFO with registered storage, full/empty and occupancy.
module mby_msh_rsp_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic                       clk_i,
   input  logic                       rst_n,
   input  logic                       wr_en_i,
   input  logic [WIDTH-1:0]           wr_data_i,
   input  logic                       rd_en_i,
   output logic [WIDTH-1:0]           rd_data_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             rd_fire;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign rd_fire   = rd_en_i && !empty_o;
   assign full_o    = (count_q == CNT_W'(DEPTH));
   assign empty_o   = (count_q == '0);
   assign count_o   = count_q;
   assign rd_data_o = mem_q[rd_ptr_q];

   // NOTE: sequential state uses <= so every flop samples pre-edge values, independent of block order.
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (wr_en_i) wr_ptr_q <= ptr_inc(wr_ptr_q);
         if (rd_fire) rd_ptr_q <= ptr_inc(rd_ptr_q);
         unique case ({wr_en_i, rd_fire})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: ;
         endcase
      end
   end

   // NOTE: storage has no reset; the pointers alone define which entries are meaningful.
   always_ff @(posedge clk_i) begin
      if (wr_en_i) mem_q[wr_ptr_q] <= wr_data_i;
   end

   a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_n)
      !(wr_en_i && full_o && !rd_en_i));

endmodule

// File: rtl/mby_msh_mem_rd_dp.sv
// Read-return datapath: issues SRAM reads, tracks fixed latency, buffers tagged responses.
module mby_msh_mem_rd_dp
   import mby_msh_pkg::*;
#(
   parameter int ADDR_W    = MSH_MEM_ADDR_W,
   parameter int DATA_W    = MSH_MEM_DATA_W,
   parameter int TAG_W     = MSH_TAG_W,
   parameter int MEM_LAT   = MSH_MEM_RD_LAT,
   parameter int RSP_DEPTH = 4,
   parameter int ERR_CNT_W = 16
) (
   input  logic                 mclk,
   input  logic                 rst_n,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic [ADDR_W-1:0]    req_addr,
   input  logic [TAG_W-1:0]     req_tag,
   output logic                 mem_rd_en,
   output logic [ADDR_W-1:0]    mem_rd_addr,
   input  logic [DATA_W-1:0]    mem_rd_data,
   input  logic                 mem_rd_err,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [DATA_W-1:0]    rsp_data,
   output logic [TAG_W-1:0]     rsp_tag,
   output logic                 rsp_err,
   output logic [ERR_CNT_W-1:0] err_cnt
);

   localparam int CNT_W = $clog2(RSP_DEPTH+1);
   localparam int RSP_W = DATA_W + TAG_W + 1;

   logic [CNT_W-1:0]     pend_q, pend_d;
   logic [MEM_LAT-1:0]   pipe_vld_q;
   logic [TAG_W-1:0]     pipe_tag_q [MEM_LAT];
   logic [ERR_CNT_W-1:0] err_cnt_q;
   logic                 accept, consume, fifo_wr, fifo_full, fifo_empty;
   logic [RSP_W-1:0]     fifo_rd_data;
   logic [CNT_W-1:0]     fifo_count;

   // Pending counts every accepted read not yet consumed, so FIFO space is reserved at accept.
   assign req_ready   = rst_n && (pend_q < CNT_W'(RSP_DEPTH));
   assign accept      = req_valid && req_ready;
   assign consume     = rsp_valid && rsp_ready;
   assign mem_rd_en   = accept;
   assign mem_rd_addr = req_addr;
   assign fifo_wr     = pipe_vld_q[MEM_LAT-1];
   assign rsp_valid   = !fifo_empty;
   assign err_cnt     = err_cnt_q;
   assign {rsp_data, rsp_tag, rsp_err} = fifo_rd_data;

   // NOTE: assign a default first so no path leaves pend_d unassigned and infers a latch.
   always_comb begin
      pend_d = pend_q;
      unique case ({accept, consume})
         2'b10:   pend_d = pend_q + CNT_W'(1);
         2'b01:   pend_d = pend_q - CNT_W'(1);
         default: ;
      endcase
   end

   always_ff @(posedge mclk or negedge rst_n) begin
      if (!rst_n) begin
         pend_q     <= '0;
         pipe_vld_q <= '0;
         err_cnt_q  <= '0;
      end else begin
         pend_q        <= pend_d;
         pipe_vld_q[0] <= accept;
         for (int i = 1; i < MEM_LAT; i++) pipe_vld_q[i] <= pipe_vld_q[i-1];
         if (fifo_wr && mem_rd_err && (err_cnt_q != '1)) err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
      end
   end

   always_ff @(posedge mclk) begin
      pipe_tag_q[0] <= req_tag;
      for (int i = 1; i < MEM_LAT; i++) pipe_tag_q[i] <= pipe_tag_q[i-1];
   end

   mby_msh_rsp_fifo #(
      .DEPTH (RSP_DEPTH),
      .WIDTH (RSP_W)
   ) u_rsp_fifo (
      .clk_i     (mclk),
      .rst_n     (rst_n),
      .wr_en_i   (fifo_wr),
      .wr_data_i ({mem_rd_data, pipe_tag_q[MEM_LAT-1], mem_rd_err}),
      .rd_en_i   (consume),
      .rd_data_o (fifo_rd_data),
      .full_o    (fifo_full),
      .empty_o   (fifo_empty),
      .count_o   (fifo_count)
   );

   a_no_full_write: assert property (@(posedge mclk) disable iff (!rst_n)
      !(fifo_wr && fifo_full && !consume));
   a_rsp_stable: assert property (@(posedge mclk) disable iff (!rst_n)
      (rsp_valid && !rsp_ready) |=> (rsp_valid && $stable(rsp_data) && $stable(rsp_tag) && $stable(rsp_err)));
   a_pend_bound: assert property (@(posedge mclk) disable iff (!rst_n)
      (pend_q <= CNT_W'(RSP_DEPTH)) && (pend_q >= fifo_count));

endmodule

// File: tb/tb_mby_msh_mem_rd_dp.sv
// Bench for mby_msh_mem_rd_dp: timestamped scoreboard model, a backpressure vector table, directed corners.
module tb_mby_msh_mem_rd_dp;
   import mby_msh_pkg::*;

   localparam int ADDR_W    = 14;
   localparam int DATA_W    = 512;
   localparam int TAG_W     = 8;
   localparam int MEM_LAT   = 2;
   localparam int RSP_DEPTH = 4;
   localparam int ERR_CNT_W = 5;
   localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

   logic                 mclk, rst_n;
   logic                 req_valid, req_ready;
   logic [ADDR_W-1:0]    req_addr;
   logic [TAG_W-1:0]     req_tag;
   logic                 mem_rd_en;
   logic [ADDR_W-1:0]    mem_rd_addr;
   logic [DATA_W-1:0]    mem_rd_data;
   logic                 mem_rd_err;
   logic                 rsp_valid, rsp_ready;
   logic [DATA_W-1:0]    rsp_data;
   logic [TAG_W-1:0]     rsp_tag;
   logic                 rsp_err;
   logic [ERR_CNT_W-1:0] err_cnt;

   mby_msh_mem_rd_dp #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_W(TAG_W),
      .MEM_LAT(MEM_LAT), .RSP_DEPTH(RSP_DEPTH), .ERR_CNT_W(ERR_CNT_W)
   ) dut (
      .mclk(mclk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_tag(req_tag),
      .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data), .mem_rd_err(mem_rd_err),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_tag(rsp_tag),
      .rsp_err(rsp_err), .err_cnt(err_cnt)
   );

   initial mclk = 1'b0;
   always #5 mclk = ~mclk;

   function automatic logic [DATA_W-1:0] data_of(input logic [ADDR_W-1:0] a);
      logic [DATA_W-1:0] d;
      for (int i = 0; i < DATA_W/32; i++) d[i*32 +: 32] = 32'hDEADBEEF ^ {a, 18'(i)};
      return d;
   endfunction

   function automatic logic err_of(input logic [ADDR_W-1:0] a);
      return (a[13:8] == 6'h3F);
   endfunction

   // SRAM model: the address presented in cycle N returns its data in cycle N+MEM_LAT.
   logic [ADDR_W-1:0] sram_pipe [MEM_LAT];
   always @(posedge mclk) begin
      sram_pipe[0] <= mem_rd_addr;
      for (int i = 1; i < MEM_LAT; i++) sram_pipe[i] <= sram_pipe[i-1];
   end
   assign mem_rd_data = data_of(sram_pipe[MEM_LAT-1]);
   assign mem_rd_err  = err_of(sram_pipe[MEM_LAT-1]);

   typedef struct {
      msh_rd_rsp_t rsp;
      int          rdy;
   } exp_t;

   exp_t exp_q[$];
   int   model_pend = 0;
   int   model_err  = 0;
   int   cyc        = 0;
   int   total      = 0;
   int   bad        = 0;

   task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s @cyc %0d: got %0h want %0h", name, cyc, act, exp);
      end
   endtask

   function automatic logic [ERR_CNT_W-1:0] exp_err();
      return (model_err > int'(ERR_MAX)) ? ERR_MAX : ERR_CNT_W'(model_err);
   endfunction

   task automatic do_reset();
      rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0; req_addr = '0; req_tag = '0;
      repeat (2) @(posedge mclk);
      @(negedge mclk);
      rst_n = 1'b1;
      @(posedge mclk); #1;
      exp_q.delete();
      model_pend = 0;
      model_err  = 0;
   endtask

   // One cycle against the model: a response is due MEM_LAT+1 cycles after its accept.
   task automatic tick(input logic rv, input logic [ADDR_W-1:0] a, input logic [TAG_W-1:0] t, input logic rr);
      logic exp_rdy, exp_acc, exp_rsp;
      exp_t e;
      req_valid = rv; req_addr = a; req_tag = t; rsp_ready = rr;
      @(negedge mclk);
      exp_rdy = (model_pend < RSP_DEPTH);
      exp_acc = rv && exp_rdy;
      exp_rsp = (exp_q.size() != 0) && (exp_q[0].rdy <= cyc);
      check("req_ready", req_ready, exp_rdy);
      check("mem_rd_en", mem_rd_en, exp_acc);
      if (exp_acc) check("mem_rd_addr", mem_rd_addr, a);
      check("rsp_valid", rsp_valid, exp_rsp);
      if (exp_rsp) begin
         check("rsp_data", rsp_data, exp_q[0].rsp.data);
         check("rsp_tag", rsp_tag, exp_q[0].rsp.tag);
         check("rsp_err", rsp_err, exp_q[0].rsp.err);
      end
      if (exp_acc) begin
         e.rsp.data = data_of(a);
         e.rsp.tag  = t;
         e.rsp.err  = err_of(a);
         e.rdy      = cyc + MEM_LAT + 1;
         exp_q.push_back(e);
         model_pend++;
         if (err_of(a)) model_err++;
      end
      if (exp_rsp && rr) begin
         void'(exp_q.pop_front());
         model_pend--;
      end
      @(posedge mclk); #1;
      cyc++;
   endtask

   task automatic idle(input int n, input logic rr);
      repeat (n) tick(1'b0, '0, '0, rr);
   endtask

   typedef struct {
      logic             rv;
      logic [TAG_W-1:0] tag;
      logic             rr;
      logic             e_rdy;
      logic             e_en;
      logic             e_rsp;
      logic [TAG_W-1:0] e_tag;
   } vec_t;

   vec_t vt [14];

   initial begin
      //            rv    tag    rr    rdy   en    rsp   etag
      vt[0]  = '{1'b1, 8'h10, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00};
      vt[1]  = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00};
      vt[2]  = '{1'b1, 8'h12, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00};
      vt[3]  = '{1'b1, 8'h13, 1'b0, 1'b1, 1'b1, 1'b1, 8'h10};
      vt[4]  = '{1'b1, 8'h14, 1'b0, 1'b0, 1'b0, 1'b1, 8'h10};
      vt[5]  = '{1'b1, 8'h14, 1'b0, 1'b0, 1'b0, 1'b1, 8'h10};
      vt[6]  = '{1'b1, 8'h14, 1'b1, 1'b0, 1'b0, 1'b1, 8'h10};
      vt[7]  = '{1'b1, 8'h14, 1'b0, 1'b1, 1'b1, 1'b1, 8'h11};
      vt[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11};
      vt[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h11};
      vt[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'h12};
      vt[11] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'h13};
      vt[12] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'h14};
      vt[13] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};

      do_reset();
      check("reset rsp_valid", rsp_valid, 1'b0);
      check("reset err_cnt", err_cnt, '0);

      // Single read with minimum latency.
      tick(1'b1, 14'h0010, 8'h5A, 1'b1);
      idle(5, 1'b1);

      // Back-to-back stream of 64 with the sink always ready.
      for (int i = 0; i < 64; i++) tick(1'b1, ADDR_W'(16'h0200 + i), TAG_W'(i), 1'b1);
      idle(5, 1'b1);
      check("stream drained", exp_q.size(), 0);

      // Backpressure table from a clean state.
      do_reset();
      for (int k = 0; k < 14; k++) begin
         req_valid = vt[k].rv; req_addr = ADDR_W'(vt[k].tag); req_tag = vt[k].tag; rsp_ready = vt[k].rr;
         @(negedge mclk);
         check($sformatf("vec%0d req_ready", k), req_ready, vt[k].e_rdy);
         check($sformatf("vec%0d mem_rd_en", k), mem_rd_en, vt[k].e_en);
         check($sformatf("vec%0d rsp_valid", k), rsp_valid, vt[k].e_rsp);
         if (vt[k].e_rsp) begin
            check($sformatf("vec%0d rsp_tag", k), rsp_tag, vt[k].e_tag);
            check($sformatf("vec%0d rsp_data", k), rsp_data, data_of(ADDR_W'(vt[k].e_tag)));
         end
         @(posedge mclk); #1;
         cyc++;
      end

      // Accept and consume together with two entries buffered, then refill to the limit.
      do_reset();
      tick(1'b1, 14'h0100, 8'hA0, 1'b0);
      tick(1'b1, 14'h0101, 8'hA1, 1'b0);
      idle(3, 1'b0);
      tick(1'b1, 14'h0102, 8'hA2, 1'b1);
      tick(1'b1, 14'h0103, 8'hA3, 1'b0);
      tick(1'b1, 14'h0104, 8'hA4, 1'b0);
      tick(1'b1, 14'h0105, 8'hA5, 1'b0);
      idle(8, 1'b1);

      // ECC: three errored returns among clean ones, then drive the counter into saturation.
      do_reset();
      tick(1'b1, 14'h3F01, 8'hE1, 1'b1);
      tick(1'b1, 14'h0301, 8'hC1, 1'b1);
      tick(1'b1, 14'h3F02, 8'hE2, 1'b1);
      tick(1'b1, 14'h3F03, 8'hE3, 1'b1);
      tick(1'b1, 14'h0302, 8'hC2, 1'b1);
      idle(5, 1'b1);
      check("err_cnt three", err_cnt, 5'd3);
      for (int i = 0; i < 30; i++) tick(1'b1, ADDR_W'(16'h3F10 + i), TAG_W'(i), 1'b1);
      idle(5, 1'b1);
      check("err_cnt saturated", err_cnt, ERR_MAX);

      // Randomized traffic against the scoreboard.
      do_reset();
      for (int i = 0; i < 400; i++)
         tick(1'($urandom_range(0, 3) != 0), ADDR_W'($urandom), TAG_W'($urandom), 1'($urandom_range(0, 2) != 0));
      idle(8, 1'b1);
      check("random err_cnt", err_cnt, exp_err());
      check("random drained", exp_q.size(), 0);

      // Reset with two reads in the latency pipe and two in the FIFO.
      tick(1'b1, 14'h0400, 8'h40, 1'b0);
      tick(1'b1, 14'h0401, 8'h41, 1'b0);
      tick(1'b1, 14'h0402, 8'h42, 1'b0);
      tick(1'b1, 14'h0403, 8'h43, 1'b0);
      rst_n = 1'b0; req_valid = 1'b1; req_addr = 14'h0404; req_tag = 8'h44;
      #1;
      check("mid reset rsp_valid", rsp_valid, 1'b0);
      check("mid reset req_ready", req_ready, 1'b0);
      check("mid reset mem_rd_en", mem_rd_en, 1'b0);
      do_reset();
      idle(6, 1'b1);
      tick(1'b1, 14'h0555, 8'h77, 1'b1);
      idle(5, 1'b1);
      check("post reset err_cnt", err_cnt, exp_err());

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
